ps2_host_port: RTL and testbench

//  Host-side PS/2 serial engine, the 8042 controller's side of the cable facing ps2_device.

---
 rtl/ps2_host_port_pkg.sv | 21 ++
 rtl/ps2_host_rxfifo.sv | 56 +++++
 rtl/ps2_host_port.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_host_port.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_port_pkg.sv
// rtl/ps2_host_port_pkg.sv - PS/2 host FSM encodings, frame constants and timing helper
package ps2_host_port_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_TX_INH  = 3'd2,
        ST_TX_RTS  = 3'd3,
        ST_TX_BITS = 3'd4,
        ST_TX_ACK  = 3'd5
    } ps2_state_t;

    // start + 8 data + parity + stop; the device ack follows the stop bit
    localparam int FRAME_LEN   = 11;
    localparam int ACK_BIT_POS = 11;

    function automatic int us_to_cycles(input int clk_hz, input int us);
        return (clk_hz / 1000000) * us;
    endfunction

endpackage

// File: rtl/ps2_host_rxfifo.sv
// rtl/ps2_host_rxfifo.sv - synchronous RX byte FIFO, depth 2**RXFIFO_BITS, push+pop when full allowed
module ps2_host_rxfifo #(
    parameter int RXFIFO_BITS = 3
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_full,
    output logic       o_empty
);
    localparam int DEPTH = 2 ** RXFIFO_BITS;

    logic [7:0]             r_mem [DEPTH];
    logic [RXFIFO_BITS-1:0] r_wr_ptr;
    logic [RXFIFO_BITS-1:0] r_rd_ptr;
    logic [RXFIFO_BITS:0]   r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    assign o_full    = (r_count == (RXFIFO_BITS+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // a pop in the same cycle frees the slot the push needs
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk_sys) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_host_port.sv
// rtl/ps2_host_port.sv - PS/2 host engine: device frames into RX FIFO, host commands via inhibit/RTS/ack
// Define PS2_HOST_WDOG_EN to add the per-frame watchdog.
module ps2_host_port
    import ps2_host_port_pkg::*;
#(
    parameter int CLK_HZ      = 50000000,
    parameter int INHIBIT_US  = 110,
    parameter int RXFIFO_BITS = 3,
    parameter int TIMEOUT_US  = 2000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_o,
    output logic       ps2_dat_o,
    input  logic       inhibit,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_perr,
    output logic       busy
);
    localparam int PRESC_MAX = us_to_cycles(CLK_HZ, 1) - 1;
    localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam int TMR_MAX   = (INHIBIT_US > TIMEOUT_US) ? INHIBIT_US : TIMEOUT_US;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);
    localparam int RX_BITS   = FRAME_LEN - 1;
    localparam int TX_BITS   = ACK_BIT_POS - 1;

    ps2_state_t       r_state;
    logic             r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic [PRESC_W-1:0] r_presc;
    logic [TMR_W-1:0] r_inh_cnt;
    logic [3:0]       r_bit_cnt;
    logic [9:0]       r_tx_shift;
    logic [9:0]       r_rx_shift;
    logic             r_clk_o, r_dat_o, r_tx_ready, r_tx_done, r_tx_err;
    logic             r_push, r_perr_set, r_rx_perr;
    logic             w_clk_fall, w_dat, w_tick, w_tx_accept, w_pop, w_full, w_empty;
    logic [9:0]       w_rx_frame;

    assign w_clk_fall  = r_clk_s2 && !r_clk_s1;
    assign w_dat       = r_dat_s2;
    assign w_tick      = (r_presc == PRESC_W'(PRESC_MAX));
    assign w_tx_accept = tx_valid && r_tx_ready;
    assign w_pop       = rx_ready && rx_valid;
    assign w_rx_frame  = {w_dat, r_rx_shift[9:1]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_dat_i;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // realigned on TX accept so the inhibit hold is an exact number of ticks
    always_ff @(posedge clk_sys) begin
        if (reset || w_tx_accept || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

`ifdef PS2_HOST_WDOG_EN
    logic [TMR_W-1:0] r_wd_cnt;
    logic             w_wd_expire;

    assign w_wd_expire = (r_wd_cnt == TMR_W'(TIMEOUT_US));

    always_ff @(posedge clk_sys) begin
        if (reset || r_state == ST_IDLE || w_clk_fall) begin
            r_wd_cnt <= '0;
        end else if (w_tick && !w_wd_expire) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_clk_o    <= 1'b1;
            r_dat_o    <= 1'b1;
            r_tx_ready <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_push     <= 1'b0;
            r_perr_set <= 1'b0;
            r_inh_cnt  <= '0;
            r_bit_cnt  <= '0;
            r_tx_shift <= '1;
            r_rx_shift <= '0;
        end else begin
            r_tx_ready <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_push     <= 1'b0;
            r_perr_set <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dat_o <= 1'b1;
                    if (w_tx_accept) begin
                        r_tx_shift <= {1'b1, ~^tx_data, tx_data};
                        r_clk_o    <= 1'b0;
                        r_inh_cnt  <= '0;
                        r_state    <= ST_TX_INH;
                    end else if (inhibit) begin
                        r_clk_o <= 1'b0;
                    end else begin
                        r_clk_o <= 1'b1;
                        // r_clk_o guard: our own inhibit release is not a device start bit
                        if (w_clk_fall && !w_dat && r_clk_o) begin
                            r_bit_cnt <= '0;
                            r_state   <= ST_RX;
                        end else begin
                            r_tx_ready <= 1'b1;
                        end
                    end
                end
                ST_RX: begin
                    if (w_clk_fall) begin
                        r_rx_shift <= w_rx_frame;
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(RX_BITS - 1)) begin
                            r_state <= ST_IDLE;
                            if ((^w_rx_frame[8:0]) && w_rx_frame[9]) begin
                                r_push <= 1'b1;
                            end else begin
                                r_perr_set <= 1'b1;
                            end
                        end
                    end
                end
                ST_TX_INH: begin
                    if (w_tick) begin
                        if (r_inh_cnt == TMR_W'(INHIBIT_US - 1)) begin
                            r_dat_o <= 1'b0;
                            r_state <= ST_TX_RTS;
                        end else begin
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                        end
                    end
                end
                ST_TX_RTS: begin
                    r_clk_o   <= 1'b1;
                    r_bit_cnt <= '0;
                    r_state   <= ST_TX_BITS;
                end
                ST_TX_BITS: begin
                    if (w_clk_fall) begin
                        r_dat_o    <= r_tx_shift[0];
                        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
                        r_bit_cnt  <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'(TX_BITS - 1)) begin
                            r_state <= ST_TX_ACK;
                        end
                    end
                end
                ST_TX_ACK: begin
                    r_dat_o <= 1'b1;
                    if (w_clk_fall) begin
                        r_tx_done <= 1'b1;
                        r_tx_err  <= w_dat;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
`ifdef PS2_HOST_WDOG_EN
            if (r_state != ST_IDLE && w_wd_expire) begin
                r_state    <= ST_IDLE;
                r_clk_o    <= 1'b1;
                r_dat_o    <= 1'b1;
                r_push     <= 1'b0;
                r_perr_set <= 1'b0;
                if (r_state != ST_RX) begin
                    r_tx_done <= 1'b1;
                    r_tx_err  <= 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_rx_perr <= 1'b0;
        end else if (r_perr_set || (r_push && w_full && !w_pop)) begin
            r_rx_perr <= 1'b1;
        end else if (w_pop) begin
            r_rx_perr <= 1'b0;
        end
    end

    ps2_host_rxfifo #(
        .RXFIFO_BITS (RXFIFO_BITS)
    ) u_rxfifo (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .i_push      (r_push),
        .i_push_data (r_rx_shift[7:0]),
        .i_pop       (w_pop),
        .o_head      (rx_data),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign ps2_clk_o = r_clk_o;
    assign ps2_dat_o = r_dat_o;
    assign tx_ready  = r_tx_ready;
    assign tx_done   = r_tx_done;
    assign tx_err    = r_tx_err;
    assign rx_valid  = !w_empty;
    assign rx_perr   = r_rx_perr;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_host_port.sv
// tb/tb_ps2_host_port.sv - randomized self-checking bench for ps2_host_port with a behavioural PS/2 device
`timescale 1ns/1ps
module tb_ps2_host_port;
    localparam int CLK_HZ      = 50000000;
    localparam int INHIBIT_US  = 110;
    localparam int RXFIFO_BITS = 3;
    localparam int TIMEOUT_US  = 200;
    localparam int CPU         = CLK_HZ / 1000000;
    localparam int H           = 60;
    localparam int DEPTH       = 1 << RXFIFO_BITS;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       line_clk, line_dat;
    logic       ps2_clk_o, ps2_dat_o;
    logic       inhibit = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       rx_perr, busy;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q[$];

    assign line_clk = ps2_clk_o & dev_clk;
    assign line_dat = ps2_dat_o & dev_dat;

    always #10 clk_sys = ~clk_sys;

    ps2_host_port #(
        .CLK_HZ      (CLK_HZ),
        .INHIBIT_US  (INHIBIT_US),
        .RXFIFO_BITS (RXFIFO_BITS),
        .TIMEOUT_US  (TIMEOUT_US)
    ) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk_i (line_clk),
        .ps2_dat_i (line_dat),
        .ps2_clk_o (ps2_clk_o),
        .ps2_dat_o (ps2_dat_o),
        .inhibit   (inhibit),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_perr   (rx_perr),
        .busy      (busy)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    function automatic logic odd_par(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2 == 0);
    endfunction

    // device-to-host frame: data changes while clock is high, host samples on the fall
    task automatic dev_send(input logic [7:0] b, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, odd_par(b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            dev_dat = f[i];
            cyc(H / 2);
            dev_clk = 1'b0;
            cyc(H);
            dev_clk = 1'b1;
            cyc(H / 2);
        end
        dev_dat = 1'b1;
        cyc(4);
    endtask

    task automatic dev_recv(input bit ack_en, output logic [10:0] got, output int inh, output bit ok);
        int t;
        got = '0;
        inh = 0;
        ok = 1'b1;
        t = 0;
        while (line_clk !== 1'b0 && t < 200) begin cyc(1); t++; end
        if (t >= 200) ok = 1'b0;
        while (line_clk === 1'b0 && inh < 20000) begin cyc(1); inh++; end
        got[0] = line_dat;
        cyc(H / 2);
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 1'b0;
            cyc(H);
            got[i] = line_dat;
            dev_clk = 1'b1;
            cyc(H);
        end
        dev_dat = ack_en ? 1'b0 : 1'b1;
        cyc(H / 2);
        dev_clk = 1'b0;
        cyc(H);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        cyc(H / 2);
    endtask

    task automatic watch_done(output bit seen, output logic err);
        seen = 1'b0;
        err = 1'b0;
        for (int t = 0; t < 12000 && !seen; t++) begin
            cyc(1);
            if (tx_done === 1'b1) begin
                seen = 1'b1;
                err = tx_err;
            end
        end
    endtask

    task automatic host_send(input logic [7:0] b, input bit ack_en, output logic [10:0] got,
                             output int inh, output bit done_seen, output logic done_err, output bit ok);
        int t;
        bit rok;
        t = 0;
        tx_data = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 100) begin cyc(1); t++; end
        ok = (t < 100);
        cyc(1);
        tx_valid = 1'b0;
        fork
            dev_recv(ack_en, got, inh, rok);
            watch_done(done_seen, done_err);
        join
        if (!rok) ok = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] exp;
        exp = (q.size() > 0) ? q.pop_front() : 8'h00;
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== exp) begin
            n_bad++;
            $display("FAIL %s: rx_valid=%b rx_data=%02h, want rx_valid=1 rx_data=%02h", name, rx_valid, rx_data, exp);
        end
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(4);
        reset = 1'b0;
        n_cmp++;
        if ({ps2_clk_o, ps2_dat_o, rx_valid, tx_ready, tx_done, tx_err, rx_perr, busy} !== 8'b1100_0000) begin
            n_bad++;
            $display("FAIL reset_state: clk_o,dat_o,rx_valid,tx_ready,tx_done,tx_err,rx_perr,busy=%b want 11000000",
                     {ps2_clk_o, ps2_dat_o, rx_valid, tx_ready, tx_done, tx_err, rx_perr, busy});
        end
        cyc(1);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_tx_ready: got %b want 1", tx_ready);
        end
    endtask

    task automatic test_inhibit();
        inhibit = 1'b1;
        cyc(2);
        n_cmp++;
        if (ps2_clk_o !== 1'b0 || tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL inhibit_hold: clk_o=%b tx_ready=%b want 0 0", ps2_clk_o, tx_ready);
        end
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        cyc(5);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL inhibit_no_accept: busy=%b want 0", busy);
        end
        tx_valid = 1'b0;
        inhibit = 1'b0;
        cyc(2);
        n_cmp++;
        if (ps2_clk_o !== 1'b1 || tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL inhibit_release: clk_o=%b tx_ready=%b want 1 1", ps2_clk_o, tx_ready);
        end
    endtask

    task automatic test_rx_basic();
        dev_send(8'hFA, 1'b0);
        q.push_back(8'hFA);
        n_cmp++;
        if (rx_perr !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_fa_perr: got %b want 0", rx_perr);
        end
        pop_check("rx_fa");
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_fa_empty: rx_valid=%b want 0", rx_valid);
        end
    endtask

    task automatic test_rx_random();
        logic [7:0] b;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom_range(0, 255));
            dev_send(b, 1'b0);
            q.push_back(b);
            if ($urandom_range(0, 1) == 1) pop_check("rx_rand");
        end
        while (q.size() > 0) pop_check("rx_rand_drain");
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_perr !== 1'b0) begin
            n_bad++;
            $display("FAIL rx_rand_end: rx_valid=%b rx_perr=%b want 0 0", rx_valid, rx_perr);
        end
    endtask

    task automatic test_parity_err();
        dev_send(8'h55, 1'b1);
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_perr !== 1'b1) begin
            n_bad++;
            $display("FAIL bad_parity: rx_valid=%b rx_perr=%b want 0 1", rx_valid, rx_perr);
        end
        dev_send(8'hAA, 1'b0);
        q.push_back(8'hAA);
        n_cmp++;
        if (rx_perr !== 1'b1) begin
            n_bad++;
            $display("FAIL perr_sticky: got %b want 1", rx_perr);
        end
        pop_check("after_perr");
        n_cmp++;
        if (rx_perr !== 1'b0 || rx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL perr_clear: rx_perr=%b rx_valid=%b want 0 0", rx_perr, rx_valid);
        end
    endtask

    task automatic test_fifo_full();
        logic model_perr;
        model_perr = 1'b0;
        for (int k = 1; k <= DEPTH + 1; k++) begin
            dev_send(8'(k), 1'b0);
            if (q.size() < DEPTH) q.push_back(8'(k));
            else model_perr = 1'b1;
        end
        n_cmp++;
        if (rx_perr !== model_perr) begin
            n_bad++;
            $display("FAIL fifo_overflow_perr: got %b want %b", rx_perr, model_perr);
        end
        while (q.size() > 0) pop_check("fifo_order");
        n_cmp++;
        if (rx_valid !== 1'b0 || rx_perr !== 1'b0) begin
            n_bad++;
            $display("FAIL fifo_drained: rx_valid=%b rx_perr=%b want 0 0", rx_valid, rx_perr);
        end
    endtask

    task automatic test_tx();
        logic [7:0]  b;
        logic [10:0] got;
        int          inh;
        bit          seen, ok;
        logic        err;
        for (int k = 0; k < 3; k++) begin
            b = (k == 0) ? 8'hFF : 8'($urandom_range(0, 255));
            host_send(b, 1'b1, got, inh, seen, err, ok);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL tx_handshake: byte %02h not accepted or no inhibit seen", b);
            end
            n_cmp++;
            if (inh < INHIBIT_US * CPU - 8 || inh > INHIBIT_US * CPU + 8) begin
                n_bad++;
                $display("FAIL tx_inhibit_len: got %0d cycles want %0d +-8", inh, INHIBIT_US * CPU);
            end
            n_cmp++;
            if (got !== {1'b1, odd_par(b), b, 1'b0}) begin
                n_bad++;
                $display("FAIL tx_frame: got %03h want %03h", got, {1'b1, odd_par(b), b, 1'b0});
            end
            n_cmp++;
            if (seen !== 1'b1 || err !== 1'b0) begin
                n_bad++;
                $display("FAIL tx_done_ack: done=%b err=%b want 1 0", seen, err);
            end
        end
        n_cmp++;
        if (busy !== 1'b0 || ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1) begin
            n_bad++;
            $display("FAIL tx_idle: busy=%b clk_o=%b dat_o=%b want 0 1 1", busy, ps2_clk_o, ps2_dat_o);
        end
    endtask

    task automatic test_tx_noack();
        logic [10:0] got;
        int          inh;
        bit          seen, ok;
        logic        err;
        host_send(8'hED, 1'b0, got, inh, seen, err, ok);
        n_cmp++;
        if (got !== {1'b1, odd_par(8'hED), 8'hED, 1'b0}) begin
            n_bad++;
            $display("FAIL noack_frame: got %03h want %03h", got, {1'b1, odd_par(8'hED), 8'hED, 1'b0});
        end
        n_cmp++;
        if (!ok || seen !== 1'b1 || err !== 1'b1) begin
            n_bad++;
            $display("FAIL noack_err: ok=%b done=%b err=%b want 1 1 1", ok, seen, err);
        end
    endtask

    task automatic test_reset_midframe();
        int t;
        t = 0;
        tx_data = 8'($urandom_range(0, 255));
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && t < 100) begin cyc(1); t++; end
        cyc(1);
        tx_valid = 1'b0;
        cyc(100);
        n_cmp++;
        if (busy !== 1'b1 || ps2_clk_o !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_inhibit: busy=%b clk_o=%b want 1 0", busy, ps2_clk_o);
        end
        reset = 1'b1;
        cyc(1);
        n_cmp++;
        if (busy !== 1'b0 || ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1 || tx_done !== 1'b0) begin
            n_bad++;
            $display("FAIL midframe_reset: busy=%b clk_o=%b dat_o=%b tx_done=%b want 0 1 1 0",
                     busy, ps2_clk_o, ps2_dat_o, tx_done);
        end
        reset = 1'b0;
        cyc(2);
        n_cmp++;
        if (tx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midframe_ready: got %b want 1", tx_ready);
        end
    endtask

`ifdef PS2_HOST_WDOG_EN
    task automatic test_watchdog();
        int t;
        bit done_seen, was_busy;
        done_seen = 1'b0;
        was_busy = 1'b0;
        dev_dat = 1'b0;
        cyc(H / 2);
        dev_clk = 1'b0;
        for (t = 0; t < 20000; t++) begin
            cyc(1);
            if (t == H) begin
                was_busy = busy;
                dev_clk = 1'b1;
            end
            if (tx_done === 1'b1) done_seen = 1'b1;
            if (t > H && busy === 1'b0) break;
        end
        n_cmp++;
        if (!was_busy || t < TIMEOUT_US * CPU - CPU - 10 || t > TIMEOUT_US * CPU + 10) begin
            n_bad++;
            $display("FAIL wdog_time: busy_seen=%b idle after %0d cycles want ~%0d", was_busy, t, TIMEOUT_US * CPU);
        end
        n_cmp++;
        if (done_seen || rx_perr !== 1'b0 || rx_valid !== 1'b0 || ps2_clk_o !== 1'b1 || ps2_dat_o !== 1'b1) begin
            n_bad++;
            $display("FAIL wdog_rx_clean: done=%b perr=%b valid=%b clk_o=%b dat_o=%b want 0 0 0 1 1",
                     done_seen, rx_perr, rx_valid, ps2_clk_o, ps2_dat_o);
        end
        dev_dat = 1'b1;
        cyc(10);
    endtask
`endif

    initial begin
        cyc(1);
        test_reset();
        test_inhibit();
        test_rx_basic();
        test_rx_random();
        test_parity_err();
        test_fifo_full();
        test_tx();
        test_tx_noack();
        test_reset_midframe();
`ifdef PS2_HOST_WDOG_EN
        test_watchdog();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
